// File: rtl/spi_reg_ctrl_if.sv
// Register-bus bundle between the SPI command sequencer and the 8-bit
// register bank.
//
//   reg_addr  : 7-bit register address
//   reg_wdata : write data
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read data, valid the cycle after reg_re
//
// master : the sequencer (drives address, data and strobes)
// slave  : the register bank (returns read data)
interface spi_reg_ctrl_if;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer for the on-chip 8-bit register bank.
//
// The first byte of every SSEL-framed transaction is a command:
// bit7 = 1 means read, bit7 = 0 means write, and bits[6:0] give the start
// address. Every following byte becomes a register write, or triggers the
// read of the next address, with 7-bit auto-increment. The block keeps tx
// loaded ahead of the slave's next shift-out, counts completed
// transactions and flags bytes that arrive while a read is in flight.
//
// Ports:
//   clk           : system clock, shared with the SPI byte slave
//   reset         : asynchronous, active-low reset
//   ssel_active   : synchronized SSEL asserted
//   rx            : last received byte, valid with byte_received
//   byte_received : one-cycle pulse per received byte
//   tx            : byte the slave loads at the next byte start
//   bus           : register bus (master side)
//   busy          : high whenever the sequencer is not idle
//   overrun       : sticky byte-overrun flag, cleared at transaction start
//   xfer_count    : number of completed transactions (wraps)
module spi_reg_ctrl #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ssel_active,
  input  logic [7:0]         rx,
  input  logic               byte_received,
  output logic [7:0]         tx,
  spi_reg_ctrl_if.master     bus,
  output logic               busy,
  output logic               overrun,
  output logic [CNT_W-1:0]   xfer_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_CAP  = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [6:0] addr;
  logic       deselect;

  // Losing SSEL outside IDLE overrides everything else, including a byte
  // that arrives in the same cycle.
  assign deselect = (state != S_IDLE) && !ssel_active;

  always_comb begin
    state_next = state;
    if (deselect) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (ssel_active) state_next = S_CMD;
        S_CMD:     if (byte_received) state_next = rx[7] ? S_RD_REQ : S_WR;
        S_WR:      state_next = S_WR;
        S_RD_REQ:  state_next = S_RD_CAP;
        S_RD_CAP:  state_next = S_RD_WAIT;
        S_RD_WAIT: if (byte_received) state_next = S_RD_REQ;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // The read strobe is raised on the edge that enters RD_REQ, so it is
  // visible the cycle after the triggering byte; read data then comes back
  // while in RD_CAP and tx updates one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      tx            <= STATUS_BYTE;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      xfer_count    <= '0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != S_IDLE);
      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;

      if (deselect) begin
        tx <= STATUS_BYTE;
        // A frame that never delivered its command byte is not a transaction.
        if (state != S_CMD) xfer_count <= xfer_count + CNT_W'(1);
      end else begin
        case (state)
          S_IDLE: begin
            tx <= STATUS_BYTE;
            if (ssel_active) overrun <= 1'b0;
          end
          S_CMD: begin
            if (byte_received) begin
              addr <= rx[6:0];
              if (rx[7]) begin
                bus.reg_re   <= 1'b1;
                bus.reg_addr <= rx[6:0];
              end else begin
                tx <= 8'h00;
              end
            end
          end
          S_WR: begin
            if (byte_received) begin
              bus.reg_we    <= 1'b1;
              bus.reg_addr  <= addr;
              bus.reg_wdata <= rx;
              addr          <= addr + 7'd1;
            end
          end
          S_RD_REQ: begin
            if (byte_received) overrun <= 1'b1;
          end
          S_RD_CAP: begin
            tx   <= bus.reg_rdata;
            addr <= addr + 7'd1;
            if (byte_received) overrun <= 1'b1;
          end
          S_RD_WAIT: begin
            if (byte_received) begin
              bus.reg_re   <= 1'b1;
              bus.reg_addr <= addr;
            end
          end
          default: begin
            tx <= STATUS_BYTE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: drives SPI-side byte events, models the
// register bank, and checks strobes, tx sequence and counters against a
// transaction-level model.
module tb_spi_reg_ctrl;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        ssel_active;
  logic [7:0]  rx;
  logic        byte_received;
  logic [7:0]  tx;
  logic        busy;
  logic        overrun;
  logic [15:0] xfer_count;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(.STATUS_BYTE(8'hA5), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .ssel_active   (ssel_active),
    .rx            (rx),
    .byte_received (byte_received),
    .tx            (tx),
    .bus           (bus),
    .busy          (busy),
    .overrun       (overrun),
    .xfer_count    (xfer_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  // Register bank model; the pre_* port lets the bench preload contents.
  logic [7:0] mem [128];
  logic       pre_we = 1'b0;
  logic [6:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  // Strobe logs.
  logic [6:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [6:0] re_addr_q[$];

  always @(negedge clk) begin
    if (bus.reg_we === 1'b1) begin
      we_addr_q.push_back(bus.reg_addr);
      we_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_re === 1'b1) re_addr_q.push_back(bus.reg_addr);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_xfer;
    ssel_active = 1'b1;
    tick(4);
  endtask

  task automatic end_xfer;
    ssel_active = 1'b0;
    tick(4);
  endtask

  // One byte, sampling the tx value the slave would be shifting out.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
    seen = tx;
    rx = b;
    byte_received = 1'b1;
    tick(1);
    byte_received = 1'b0;
    rx = 8'($urandom);
    tick(7);
  endtask

  task automatic run_write(input logic [6:0] a, input byte_q_t d);
    logic [7:0] s;
    start_xfer();
    send_byte({1'b0, a}, s);
    foreach (d[i]) send_byte(d[i], s);
    end_xfer();
    exp_count++;
  endtask

  task automatic run_read(input logic [6:0] a, input int n, output byte_q_t seen);
    logic [7:0] s;
    seen.delete();
    start_xfer();
    send_byte({1'b1, a}, s);
    seen.push_back(s);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), s);
      seen.push_back(s);
    end
    end_xfer();
    exp_count++;
  endtask

  task automatic preload;
    for (int i = 0; i < 128; i++) begin
      pre_addr = 7'(i);
      if (i == 'h40) pre_data = 8'hDE;
      else if (i == 'h41) pre_data = 8'hAD;
      else if (i == 'h55) pre_data = 8'h3C;
      else pre_data = 8'($urandom);
      pre_we = 1'b1;
      tick(1);
    end
    pre_we = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    total++; if (tx !== 8'hA5) begin bad++; $display("[TB] FAIL reset_tx: got %h want a5", tx); end
    total++; if (bus.reg_addr !== 7'h00) begin bad++; $display("[TB] FAIL reset_addr: got %h want 00", bus.reg_addr); end
    total++; if (bus.reg_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 00", bus.reg_wdata); end
    total++; if (bus.reg_we !== 1'b0 || bus.reg_re !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes: got we=%b re=%b want 0 0", bus.reg_we, bus.reg_re); end
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got busy=%b ovr=%b want 0 0", busy, overrun); end
    total++; if (xfer_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", xfer_count); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_write_burst;
    byte_q_t d;
    logic [6:0] a;
    int base, n;
    for (int t = 0; t < 5; t++) begin
      d.delete();
      if (t == 0) begin
        a = 7'h10;
        d = {8'h11, 8'h22, 8'h33};
      end else begin
        a = 7'($urandom);
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      end
      base = we_addr_q.size();
      run_write(a, d);
      total++;
      if (we_addr_q.size() - base != d.size()) begin
        bad++; $display("[TB] FAIL wr_count t=%0d: got %0d want %0d", t, we_addr_q.size() - base, d.size());
      end else begin
        for (int i = 0; i < d.size(); i++) begin
          total++;
          if (we_addr_q[base+i] !== 7'(a + i) || we_data_q[base+i] !== d[i]) begin
            bad++; $display("[TB] FAIL wr_beat t=%0d i=%0d: got %h/%h want %h/%h", t, i, we_addr_q[base+i], we_data_q[base+i], 7'(a + i), d[i]);
          end
        end
      end
      total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL wr_xfer_count t=%0d: got %0d want %0d", t, xfer_count, exp_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy t=%0d: got %b want 0", t, busy); end
    end
  endtask

  task automatic test_wrap;
    byte_q_t d;
    logic [6:0] ea [3];
    int base;
    ea = '{7'h7E, 7'h7F, 7'h00};
    d = {8'($urandom), 8'($urandom), 8'($urandom)};
    base = we_addr_q.size();
    run_write(7'h7E, d);
    total++;
    if (we_addr_q.size() - base != 3) begin
      bad++; $display("[TB] FAIL wrap_count: got %0d want 3", we_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (we_addr_q[base+i] !== ea[i] || we_data_q[base+i] !== d[i]) begin
          bad++; $display("[TB] FAIL wrap_beat i=%0d: got %h/%h want %h/%h", i, we_addr_q[base+i], we_data_q[base+i], ea[i], d[i]);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] s;
    int base;
    base = we_addr_q.size();
    start_xfer();
    send_byte({1'b0, 7'h30}, s);
    send_byte(8'h5A, s);
    rx = 8'hC3;
    byte_received = 1'b1;
    ssel_active = 1'b0;
    tick(1);
    byte_received = 1'b0;
    exp_count++;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    tick(4);
    total++;
    if (we_addr_q.size() - base != 1) begin
      bad++; $display("[TB] FAIL abort_wr_count: got %0d want 1", we_addr_q.size() - base);
    end else if (we_addr_q[base] !== 7'h30 || we_data_q[base] !== 8'h5A) begin
      bad++; $display("[TB] FAIL abort_wr_beat: got %h/%h want 30/5a", we_addr_q[base], we_data_q[base]);
    end
    total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL abort_count: got %0d want %0d", xfer_count, exp_count); end
  endtask

  task automatic test_cmd_abort;
    ssel_active = 1'b1;
    tick(3);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL cmdabort_busy_on: got %b want 1", busy); end
    ssel_active = 1'b0;
    tick(3);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cmdabort_busy_off: got %b want 0", busy); end
    total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL cmdabort_count: got %0d want %0d", xfer_count, exp_count); end
  endtask

  task automatic test_read_burst;
    byte_q_t seen, expv;
    logic [6:0] a;
    int n, rbase, wbase;
    preload();
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        a = 7'h40; n = 2;
        expv = {8'hA5, 8'hDE, 8'hAD};
      end else begin
        a = 7'($urandom); n = $urandom_range(0, 4);
        expv = {8'hA5};
        for (int i = 0; i < n; i++) expv.push_back(mem[7'(a + i)]);
      end
      rbase = re_addr_q.size();
      wbase = we_addr_q.size();
      run_read(a, n, seen);
      for (int i = 0; i <= n; i++) begin
        total++;
        if (seen[i] !== expv[i]) begin bad++; $display("[TB] FAIL rd_tx t=%0d byte=%0d: got %h want %h", t, i, seen[i], expv[i]); end
      end
      total++;
      if (re_addr_q.size() - rbase != n + 1) begin
        bad++; $display("[TB] FAIL rd_re_count t=%0d: got %0d want %0d", t, re_addr_q.size() - rbase, n + 1);
      end else begin
        for (int i = 0; i <= n; i++) begin
          total++;
          if (re_addr_q[rbase+i] !== 7'(a + i)) begin bad++; $display("[TB] FAIL rd_re_addr t=%0d i=%0d: got %h want %h", t, i, re_addr_q[rbase+i], 7'(a + i)); end
        end
      end
      total++; if (we_addr_q.size() != wbase) begin bad++; $display("[TB] FAIL rd_no_write t=%0d: got %0d writes want 0", t, we_addr_q.size() - wbase); end
      total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL rd_count t=%0d: got %0d want %0d", t, xfer_count, exp_count); end
    end
  endtask

  // Read command followed by a byte landing while the read data is captured.
  task automatic inject_overrun;
    rx = {1'b1, 7'h55};
    byte_received = 1'b1;
    tick(1);
    byte_received = 1'b0;
    tick(1);
    rx = 8'($urandom);
    byte_received = 1'b1;
    tick(1);
    byte_received = 1'b0;
    tick(3);
  endtask

  task automatic test_overrun_reset;
    byte_q_t d;
    int base;
    start_xfer();
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_start: got %b want 0", overrun); end
    inject_overrun();
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_set: got %b want 1", overrun); end
    ssel_active = 1'b0;
    tick(3);
    exp_count++;
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); end
    total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL ovr_count: got %0d want %0d", xfer_count, exp_count); end
    ssel_active = 1'b1;
    tick(2);
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear: got %b want 0", overrun); end
    inject_overrun();
    total++; if (overrun !== 1'b1 || tx !== 8'h3C) begin bad++; $display("[TB] FAIL ovr_preset: got ovr=%b tx=%h want 1 3c", overrun, tx); end
    #2 reset = 1'b0;
    #1;
    exp_count = 0;
    total++; if (tx !== 8'hA5) begin bad++; $display("[TB] FAIL midrst_tx: got %h want a5", tx); end
    total++; if (bus.reg_addr !== 7'h00 || bus.reg_wdata !== 8'h00) begin bad++; $display("[TB] FAIL midrst_bus: got %h/%h want 00/00", bus.reg_addr, bus.reg_wdata); end
    total++; if (bus.reg_we !== 1'b0 || bus.reg_re !== 1'b0) begin bad++; $display("[TB] FAIL midrst_strobes: got we=%b re=%b want 0 0", bus.reg_we, bus.reg_re); end
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("[TB] FAIL midrst_flags: got busy=%b ovr=%b want 0 0", busy, overrun); end
    total++; if (xfer_count !== 16'h0) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 0", xfer_count); end
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    // SSEL is still asserted, so the next byte is taken as a command.
    base = we_addr_q.size();
    d = {8'h77};
    begin
      logic [7:0] s;
      send_byte({1'b0, 7'h20}, s);
      send_byte(8'h77, s);
    end
    end_xfer();
    exp_count++;
    total++;
    if (we_addr_q.size() - base != 1) begin
      bad++; $display("[TB] FAIL postrst_wr_count: got %0d want 1", we_addr_q.size() - base);
    end else if (we_addr_q[base] !== 7'h20 || we_data_q[base] !== d[0]) begin
      bad++; $display("[TB] FAIL postrst_wr_beat: got %h/%h want 20/77", we_addr_q[base], we_data_q[base]);
    end
    total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL postrst_count: got %0d want %0d", xfer_count, exp_count); end
  endtask

  task automatic test_random_mix;
    byte_q_t d, seen, expv;
    logic [6:0] a;
    int n, base;
    for (int t = 0; t < 8; t++) begin
      a = 7'($urandom);
      n = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        expv = {8'hA5};
        for (int i = 0; i < n; i++) expv.push_back(mem[7'(a + i)]);
        base = re_addr_q.size();
        run_read(a, n, seen);
        for (int i = 0; i <= n; i++) begin
          total++;
          if (seen[i] !== expv[i]) begin bad++; $display("[TB] FAIL mix_rd_tx t=%0d byte=%0d: got %h want %h", t, i, seen[i], expv[i]); end
        end
        total++; if (re_addr_q.size() - base != n + 1) begin bad++; $display("[TB] FAIL mix_re_count t=%0d: got %0d want %0d", t, re_addr_q.size() - base, n + 1); end
      end else begin
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        base = we_addr_q.size();
        run_write(a, d);
        total++;
        if (we_addr_q.size() - base != n) begin
          bad++; $display("[TB] FAIL mix_wr_count t=%0d: got %0d want %0d", t, we_addr_q.size() - base, n);
        end else begin
          for (int i = 0; i < n; i++) begin
            total++;
            if (we_addr_q[base+i] !== 7'(a + i) || we_data_q[base+i] !== d[i]) begin
              bad++; $display("[TB] FAIL mix_wr_beat t=%0d i=%0d: got %h/%h want %h/%h", t, i, we_addr_q[base+i], we_data_q[base+i], 7'(a + i), d[i]);
            end
          end
        end
      end
      total++; if (xfer_count !== 16'(exp_count)) begin bad++; $display("[TB] FAIL mix_count t=%0d: got %0d want %0d", t, xfer_count, exp_count); end
    end
  endtask

  initial begin
    reset = 1'b0;
    ssel_active = 1'b0;
    byte_received = 1'b0;
    rx = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_burst();
    test_wrap();
    test_abort();
    test_cmd_abort();
    test_read_burst();
    test_overrun_reset();
    test_random_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer between the SPI byte-level slave and the on-chip 8-bit register bank. It decodes the first byte of each SSEL-framed transaction as a read/write command with a 7-bit start address, then issues register-bus writes or reads for every following byte, auto-incrementing the address. It keeps the `tx` byte loaded in time for the slave's next shift-out. It also counts completed transactions and flags byte overruns.

## Interface
- `STATUS_BYTE`, 8'hA5: value presented on `tx` while idle and during the command byte.
- `CNT_W`, 16: width of the transaction counter.
- `clk` input 1: system clock; the same clock as the SPI slave.
- `reset` input 1: asynchronous, active-low reset.
- `ssel_active` input 1: high while the SPI slave's synchronized SSEL is asserted.
- `rx` input 8: last byte received; valid while `byte_received` is high.
- `byte_received` input 1: one-cycle pulse per received byte.
- `tx` output 8: byte the SPI slave loads at the start of the next byte.
- `reg_addr` output 7: register-bus address.
- `reg_wdata` output 8: register-bus write data.
- `reg_we` output 1: one-cycle write strobe.
- `reg_re` output 1: one-cycle read strobe.
- `reg_rdata` input 8: read data; valid the cycle after `reg_re`.
- `busy` output 1: high in any state other than IDLE.
- `overrun` output 1: sticky error flag; cleared at the next transaction start.
- `xfer_count` output CNT_W: number of completed transactions.

## Operation
- Command byte format:
  - bit7 = 1 selects read; bit7 = 0 selects write.
  - bits[6:0] give the start address.
- States and transitions:
  - IDLE: `tx` = STATUS_BYTE. Goes to CMD when `ssel_active` = 1; at the same time `overrun` is cleared.
  - CMD: waits for `byte_received`. Then `addr` ← `rx[6:0]`. Goes to RD_REQ if `rx[7]` = 1, otherwise to WR.
  - WR: on each `byte_received`, pulses `reg_we` with `reg_addr` = addr and `reg_wdata` = `rx`, then addr ← addr+1. Stays in WR. `tx` = 8'h00.
  - RD_REQ: pulses `reg_re` with `reg_addr` = addr for exactly one cycle. Goes to RD_CAP.
  - RD_CAP: `tx` ← `reg_rdata`, then addr ← addr+1. Goes to RD_WAIT.
  - RD_WAIT: on `byte_received`, goes to RD_REQ.
- Data alignment: the first read datum shifts out in the byte after the command byte. Each subsequent byte returns the next address.
- Address arithmetic: 7-bit, wraps from 7'h7F to 7'h00. There is no carry or error on wrap.
- `ssel_active` = 0 in any non-IDLE state:
  - Goes to IDLE on the next edge.
  - No strobe is issued in that cycle.
  - `xfer_count` increments only if the command byte had already been received (the state was not CMD).
- If `ssel_active` falls in the same cycle as `byte_received`, deselect wins: the byte is discarded and no `reg_we` is issued.
- A `byte_received` in RD_REQ or RD_CAP is ignored and sets `overrun` = 1.
- `xfer_count` wraps at 2^CNT_W − 1 → 0.

## Timing
- Reset values:
  - `tx` = STATUS_BYTE.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - `reg_we` = 0, `reg_re` = 0.
  - `busy` = 0, `overrun` = 0, `xfer_count` = 0.
  - State = IDLE, internal addr = 0.
- All outputs are registered.
- Write latency: `byte_received` high in cycle N gives `reg_we`, `reg_addr` and `reg_wdata` valid in cycle N+1.
- Read latency:
  - Command or data `byte_received` in cycle N gives `reg_re` in cycle N+1.
  - `reg_rdata` is sampled in cycle N+2.
  - New `tx` is visible in cycle N+3.
- Clock ratio: `clk` must be at least 8× the SCK frequency. This guarantees `tx` is settled before the slave's next byte start (at least one SCK period after `byte_received`).
- `reset` asserted mid-transaction:
  - Outputs return to reset values immediately.
  - After release, the block stays in IDLE until `ssel_active` is seen high.
  - If `ssel_active` is still high at release, it enters CMD and treats the next byte as a command.

## Test plan
- Write burst: SSEL low, bytes 0x10, 0x11, 0x22, 0x33 → `reg_we` pulses at addr 0x10/0x11/0x12 with data 0x11/0x22/0x33. After SSEL high, `xfer_count` = 1.
- Read burst: register model 0x40=0xDE, 0x41=0xAD; bytes 0xC0 plus two dummy bytes → `reg_re` at 0x40 then 0x41. `tx` = 0xA5, 0xDE, 0xAD in successive bytes, and `reg_re` at 0x42 is issued after the last byte.
- Wrap: write command to address 0x7E with 3 data bytes → writes at 0x7E, 0x7F, 0x00.
- Abort: SSEL released coincident with the 2nd data byte's `byte_received` → no `reg_we` for that byte. State is IDLE next cycle, and `xfer_count` increments.
- Command-only abort: SSEL low then high with no byte → `xfer_count` unchanged and `busy` back to 0.
- Overrun and reset: inject `byte_received` in RD_CAP → `overrun` = 1 until the next SSEL falling; assert `reset` = 0 mid-read → all outputs at reset values at once.
